// File: rtl/mod_exp_seq_if.sv
// Multiplier-side bus between the square-and-multiply controller and the
// Montgomery multiplier.
//   mm_x, mm_y : operands, driven by the controller (master)
//   mm_start   : start level, driven by the controller
//   mm_z       : product, driven by the multiplier (slave)
//   mm_done    : 1 = multiplier idle/complete, driven by the multiplier
interface mod_exp_seq_if #(
    parameter int unsigned K = 192
);
    logic [K-1:0] mm_x;
    logic [K-1:0] mm_y;
    logic         mm_start;
    logic [K-1:0] mm_z;
    logic         mm_done;

    modport master (
        output mm_x,
        output mm_y,
        output mm_start,
        input  mm_z,
        input  mm_done
    );

    modport slave (
        input  mm_x,
        input  mm_y,
        input  mm_start,
        output mm_z,
        output mm_done
    );
endinterface

// File: rtl/mod_exp_seq.sv
// Square-and-multiply controller for Montgomery-domain modular exponentiation.
// Scans the exponent MSB first and sequences SQ / MUL requests to an external
// multiplier; all arithmetic happens in the multiplier.
// Ports:
//   clk        : rising-edge clock
//   reset      : asynchronous, active-low
//   start      : request, sampled in IDLE/DONE
//   e          : exponent, latched at start
//   base_mont  : Montgomery base, latched at start
//   one_mont   : Montgomery one, loaded into the accumulator at start
//   busy       : high from accepted start until DONE
//   done       : level, high in DONE
//   err        : multiplier acknowledge timeout
//   res        : result, valid while done=1
//   mm         : multiplier bus (master side)
module mod_exp_seq #(
    parameter int unsigned K           = 192,
    parameter int unsigned LOGK        = 8,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [K-1:0]  e,
    input  logic [K-1:0]  base_mont,
    input  logic [K-1:0]  one_mont,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [K-1:0]  res,
    mod_exp_seq_if.master mm
);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StScan = 3'd1;
    localparam logic [2:0] StReq  = 3'd2;
    localparam logic [2:0] StAck  = 3'd3;
    localparam logic [2:0] StWait = 3'd4;
    localparam logic [2:0] StDone = 3'd5;

    localparam logic OpSq  = 1'b0;
    localparam logic OpMul = 1'b1;

    localparam int unsigned     TW      = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0]   TimeMax = TW'(ACK_TIMEOUT - 1);
    localparam logic [LOGK-1:0] IdxMax  = LOGK'(K - 1);

    logic [2:0]      state_q, state_d;
    logic            op_q, op_d;
    logic            seen_q, seen_d;
    logic [LOGK-1:0] idx_q, idx_d;
    logic [K-1:0]    e_q, e_d;
    logic [K-1:0]    base_q, base_d;
    logic [K-1:0]    acc_q, acc_d;
    logic [K-1:0]    res_q, res_d;
    logic [K-1:0]    mm_x_q, mm_x_d;
    logic [K-1:0]    mm_y_q, mm_y_d;
    logic            mm_start_q, mm_start_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [1:0]      gap_q, gap_d;
    logic [TW-1:0]   timer_q, timer_d;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        seen_d     = seen_q;
        idx_d      = idx_q;
        e_d        = e_q;
        base_d     = base_q;
        acc_d      = acc_q;
        res_d      = res_q;
        mm_x_d     = mm_x_q;
        mm_y_d     = mm_y_q;
        mm_start_d = mm_start_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;
        timer_d    = timer_q;
        // Consecutive cycles with mm_start low, saturating at 2.
        gap_d      = mm_start_q ? 2'd0 : ((gap_q == 2'd2) ? gap_q : gap_q + 2'd1);

        case (state_q)
            StIdle, StDone: begin
                if (state_q == StDone) begin
                    res_d  = acc_q;
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end
                if (start) begin
                    e_d     = e;
                    base_d  = base_mont;
                    acc_d   = one_mont;
                    idx_d   = IdxMax;
                    seen_d  = 1'b0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = StScan;
                end
            end
            StScan: begin
                if (seen_q) begin
                    // idx is kept; it advances once the square (and multiply) finish.
                    op_d    = OpSq;
                    mm_x_d  = acc_q;
                    mm_y_d  = acc_q;
                    state_d = StReq;
                end else begin
                    // Leading one: load base directly instead of squaring one_mont.
                    if (e_q[idx_q]) begin
                        acc_d  = base_q;
                        seen_d = 1'b1;
                    end
                    if (idx_q == '0) begin
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
                end
            end
            StReq: begin
                if (!mm_start_q) begin
                    // The gap lets the multiplier pass through its start=0 idle state.
                    if (gap_q == 2'd2) begin
                        mm_start_d = 1'b1;
                        timer_d    = '0;
                    end
                end else if (!mm.mm_done) begin
                    state_d = StAck;
                end else if (timer_q == TimeMax) begin
                    mm_start_d = 1'b0;
                    err_d      = 1'b1;
                    busy_d     = 1'b0;
                    done_d     = 1'b0;
                    state_d    = StIdle;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StAck: begin
                mm_start_d = 1'b0;
                state_d    = StWait;
            end
            StWait: begin
                if (mm.mm_done) begin
                    acc_d = mm.mm_z;
                    if (op_q == OpSq && e_q[idx_q]) begin
                        op_d    = OpMul;
                        mm_x_d  = mm.mm_z;
                        mm_y_d  = base_q;
                        state_d = StReq;
                    end else if (idx_q == '0) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q - 1'b1;
                        state_d = StScan;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            op_q       <= OpSq;
            seen_q     <= 1'b0;
            idx_q      <= IdxMax;
            e_q        <= '0;
            base_q     <= '0;
            acc_q      <= '0;
            res_q      <= '0;
            mm_x_q     <= '0;
            mm_y_q     <= '0;
            mm_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            gap_q      <= 2'd0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            seen_q     <= seen_d;
            idx_q      <= idx_d;
            e_q        <= e_d;
            base_q     <= base_d;
            acc_q      <= acc_d;
            res_q      <= res_d;
            mm_x_q     <= mm_x_d;
            mm_y_q     <= mm_y_d;
            mm_start_q <= mm_start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            gap_q      <= gap_d;
            timer_q    <= timer_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign res         = res_q;
    assign mm.mm_x     = mm_x_q;
    assign mm.mm_y     = mm_y_q;
    assign mm.mm_start = mm_start_q;

endmodule

// File: tb/tb_mod_exp_seq.sv
// Directed bench for mod_exp_seq. The multiplier is a stub computing
// (x*y) mod P with one_mont = 1, so the controller result must equal
// base^e mod P; the reference uses right-to-left exponentiation.
module tb_mod_exp_seq;

    localparam int unsigned     K  = 192;
    localparam longint unsigned P  = 64'd1000003;
    localparam int unsigned     TO = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [K-1:0] e, base_mont, one_mont, res;
    logic         busy, done, err;

    mod_exp_seq_if #(.K(K)) mm_bus ();

    mod_exp_seq #(.K(K), .LOGK(8), .ACK_TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .e         (e),
        .base_mont (base_mont),
        .one_mont  (one_mont),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .res       (res),
        .mm        (mm_bus)
    );

    always #5 clk = ~clk;

    // Multiplier stub.
    logic         stuck = 1'b0;
    logic         stab_bad = 1'b0;
    logic [1:0]   st;
    logic [1:0]   cnt;
    logic [K-1:0] cap_x, cap_y;
    longint unsigned prod;

    assign prod = (cap_x[63:0] * cap_y[63:0]) % P;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            st             <= 2'd0;
            cnt            <= 2'd0;
            cap_x          <= '0;
            cap_y          <= '0;
            mm_bus.mm_done <= 1'b1;
            mm_bus.mm_z    <= '0;
        end else begin
            case (st)
                2'd0: if (!mm_bus.mm_start && !stuck) st <= 2'd1;
                2'd1: if (mm_bus.mm_start && !stuck) begin
                    cap_x          <= mm_bus.mm_x;
                    cap_y          <= mm_bus.mm_y;
                    mm_bus.mm_done <= 1'b0;
                    cnt            <= 2'd3;
                    st             <= 2'd2;
                end
                default: begin
                    if (mm_bus.mm_x !== cap_x || mm_bus.mm_y !== cap_y) stab_bad <= 1'b1;
                    if (cnt == 2'd0) begin
                        mm_bus.mm_z    <= K'(prod);
                        mm_bus.mm_done <= 1'b1;
                        st             <= 2'd0;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
            endcase
        end
    end

    // Transaction and mm_start-high cycle monitors (monotonic).
    logic prev_start = 1'b0;
    int   n_txn = 0;
    int   hi_cycles = 0;
    always @(posedge clk) begin
        prev_start <= mm_bus.mm_start;
        if (mm_bus.mm_start && !prev_start) n_txn <= n_txn + 1;
        if (mm_bus.mm_start) hi_cycles <= hi_cycles + 1;
    end

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [K-1:0] obs, input logic [K-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [K-1:0] ev);
        e     = ev;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int n = 0;
        while (!(done || err) && n < 20000) begin
            step();
            n++;
        end
        check(tag, K'(done || err), K'(1));
    endtask

    function automatic longint unsigned model_pow(input logic [K-1:0] ee, input longint unsigned b);
        longint unsigned r = 1;
        longint unsigned t = b % P;
        for (int i = 0; i < K; i++) begin
            if (ee[i]) r = (r * t) % P;
            t = (t * t) % P;
        end
        return r;
    endfunction

    logic [K-1:0] all_ones;
    int t0, h0, n;

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        e         = '0;
        base_mont = K'(5);
        one_mont  = K'(1);
        all_ones  = '1;
        step();
        step();
        check("rst_busy", K'(busy), '0);
        check("rst_done", K'(done), '0);
        check("rst_err", K'(err), '0);
        check("rst_res", res, '0);
        check("rst_mm_start", K'(mm_bus.mm_start), '0);
        reset = 1'b1;
        step();

        // e = 0: K scan cycles plus one into DONE, no multiplications.
        t0 = n_txn;
        start_op('0);
        check("e0_busy", K'(busy), K'(1));
        repeat (K) step();
        check("e0_done_early", K'(done), '0);
        step();
        check("e0_done", K'(done), K'(1));
        check("e0_busy_low", K'(busy), '0);
        check("e0_res", res, K'(1));
        check("e0_txn", K'(n_txn - t0), '0);

        // e = 1: result is base directly.
        t0 = n_txn;
        start_op(K'(1));
        repeat (K + 1) step();
        check("e1_done", K'(done), K'(1));
        check("e1_res", res, K'(5));
        check("e1_txn", K'(n_txn - t0), '0);
        check("e1_err", K'(err), '0);

        // e = 5: SQ, SQ, MUL -> 5^5 = 3125; a start pulse mid-op is ignored.
        t0 = n_txn;
        start_op(K'(5));
        repeat (4) step();
        e     = '0;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_end("e5_end");
        check("e5_res", res, K'(3125));
        check("e5_txn", K'(n_txn - t0), K'(3));
        check("e5_err", K'(err), '0);

        // e = all ones: 191 squarings + 191 multiplies.
        t0 = n_txn;
        start_op(all_ones);
        wait_end("ones_end");
        check("ones_res", res, K'(model_pow(all_ones, 5)));
        check("ones_txn", K'(n_txn - t0), K'(382));
        check("ones_stable", K'(stab_bad), '0);
        check("ones_err", K'(err), '0);

        // Multiplier never acknowledges: timeout after TO cycles of mm_start.
        stuck = 1'b1;
        t0 = n_txn;
        h0 = hi_cycles;
        start_op(K'(3));
        wait_end("to_end");
        check("to_err", K'(err), K'(1));
        check("to_busy", K'(busy), '0);
        check("to_done", K'(done), '0);
        check("to_mm_start", K'(mm_bus.mm_start), '0);
        check("to_hi_cycles", K'(hi_cycles - h0), K'(TO));
        check("to_txn", K'(n_txn - t0), K'(1));
        stuck = 1'b0;
        step();

        // Async reset while waiting on the multiplier.
        start_op(K'(5));
        check("rw_err_cleared", K'(err), '0);
        n = 0;
        while (!(busy && !mm_bus.mm_start && !mm_bus.mm_done) && n < 5000) begin
            step();
            n++;
        end
        check("rw_in_wait", K'(busy && !mm_bus.mm_start && !mm_bus.mm_done), K'(1));
        #2;
        reset = 1'b0;
        #1;
        check("rw_busy", K'(busy), '0);
        check("rw_done", K'(done), '0);
        check("rw_err", K'(err), '0);
        check("rw_mm_start", K'(mm_bus.mm_start), '0);
        check("rw_res", res, '0);
        check("rw_mm_x", mm_bus.mm_x, '0);
        check("rw_mm_y", mm_bus.mm_y, '0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        step();
        start_op(K'(3));
        wait_end("e3_end");
        check("e3_res", res, K'(125));
        check("e3_err", K'(err), '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
